// File: rtl/register_bank.sv
// Bank of 2**ADDR_W registers with one write port and two registered read ports.
// Also provides per-entry written flags, optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module register_bank #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              valid_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              valid_b,
  input  logic              clear,
  output logic              busy,
  output logic              clear_done,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_index;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]  r_flag;
  logic [WIDTH-1:0]  r_rdata_a;
  logic [WIDTH-1:0]  r_rdata_b;
  logic              r_valid_a;
  logic              r_valid_b;
  logic              r_done;
  logic              r_drop;

  logic              w_wen;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;
  logic              w_wflag;
  logic              w_last;
  logic [WIDTH-1:0]  w_rd_a;
  logic [WIDTH-1:0]  w_rd_b;
  logic              w_vd_a;
  logic              w_vd_b;

  // The sweep shares the single write path, so bypass sees it as an ordinary write of zero.
  always_comb begin
    w_state_nxt = r_state;
    w_wen       = 1'b0;
    w_waddr     = waddr;
    w_wdata     = wdata;
    w_wflag     = 1'b1;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wen = we;
        if (clear) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_wen   = 1'b1;
        w_waddr = r_index;
        w_wdata = '0;
        w_wflag = 1'b0;
        if (r_index == '1) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_a = r_mem[raddr_a];
    w_vd_a = r_flag[raddr_a];
    w_rd_b = r_mem[raddr_b];
    w_vd_b = r_flag[raddr_b];
    if (BYPASS && w_wen && (w_waddr == raddr_a)) begin
      w_rd_a = w_wdata;
      w_vd_a = w_wflag;
    end
    if (BYPASS && w_wen && (w_waddr == raddr_b)) begin
      w_rd_b = w_wdata;
      w_vd_b = w_wflag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_flag    <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= (r_state == S_CLEAR) ? r_index + 1'b1 : '0;
      if (w_wen) begin
        r_mem[w_waddr]  <= w_wdata;
        r_flag[w_waddr] <= w_wflag;
      end
      r_rdata_a <= w_rd_a;
      r_rdata_b <= w_rd_b;
      r_valid_a <= w_vd_a;
      r_valid_b <= w_vd_b;
      r_done    <= w_last;
      r_drop    <= (r_state == S_CLEAR) && we;
    end
  end

  assign rdata_a    = r_rdata_a;
  assign rdata_b    = r_rdata_b;
  assign valid_a    = r_valid_a;
  assign valid_b    = r_valid_b;
  assign busy       = (r_state == S_CLEAR);
  assign clear_done = r_done;
  assign wr_drop    = r_drop;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: a BYPASS=1 and a BYPASS=0 instance share one stimulus stream.
// Driver pushes the expected post-edge outputs per cycle; a monitor pops and compares after each edge.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [2:0]  raddr_a = '0;
  logic [2:0]  raddr_b = '0;
  logic        clear = 1'b0;

  logic [15:0] rdata_a1, rdata_b1, rdata_a0, rdata_b0;
  logic        valid_a1, valid_b1, valid_a0, valid_b0;
  logic        busy1, done1, drop1, busy0, done0, drop0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  register_bank #(.WIDTH(16), .ADDR_W(3), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a1), .valid_a(valid_a1),
    .raddr_b(raddr_b), .rdata_b(rdata_b1), .valid_b(valid_b1),
    .clear(clear), .busy(busy1), .clear_done(done1), .wr_drop(drop1)
  );

  register_bank #(.WIDTH(16), .ADDR_W(3), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a0), .valid_a(valid_a0),
    .raddr_b(raddr_b), .rdata_b(rdata_b0), .valid_b(valid_b0),
    .clear(clear), .busy(busy0), .clear_done(done0), .wr_drop(drop0)
  );

  typedef struct {
    string       name;
    bit          crd;
    logic [15:0] a1, b1, a0, b0;
    logic        va1, vb1, va0, vb0;
    bit          cst;
    logic        bsy, dn, drp;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t xn();
    exp_t e;
    e.name = "";
    e.crd = 1'b0; e.cst = 1'b0;
    e.a1 = '0; e.b1 = '0; e.a0 = '0; e.b0 = '0;
    e.va1 = 1'b0; e.vb1 = 1'b0; e.va0 = 1'b0; e.vb0 = 1'b0;
    e.bsy = 1'b0; e.dn = 1'b0; e.drp = 1'b0;
    return e;
  endfunction

  function automatic exp_t xr(exp_t ein, string n, logic [15:0] a, logic va, logic [15:0] b, logic vb);
    exp_t e = ein;
    e.name = n; e.crd = 1'b1;
    e.a1 = a; e.va1 = va; e.b1 = b; e.vb1 = vb;
    e.a0 = a; e.va0 = va; e.b0 = b; e.vb0 = vb;
    return e;
  endfunction

  function automatic exp_t xs(exp_t ein, string n, logic bz, logic dn, logic dr);
    exp_t e = ein;
    e.name = n; e.cst = 1'b1;
    e.bsy = bz; e.dn = dn; e.drp = dr;
    return e;
  endfunction

  task automatic chk(string n, logic [15:0] act, logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.crd) begin
        chk({e.name, "_rdata_a_byp1"}, rdata_a1, e.a1);
        chk({e.name, "_valid_a_byp1"}, 16'(valid_a1), 16'(e.va1));
        chk({e.name, "_rdata_b_byp1"}, rdata_b1, e.b1);
        chk({e.name, "_valid_b_byp1"}, 16'(valid_b1), 16'(e.vb1));
        chk({e.name, "_rdata_a_byp0"}, rdata_a0, e.a0);
        chk({e.name, "_valid_a_byp0"}, 16'(valid_a0), 16'(e.va0));
        chk({e.name, "_rdata_b_byp0"}, rdata_b0, e.b0);
        chk({e.name, "_valid_b_byp0"}, 16'(valid_b0), 16'(e.vb0));
      end
      if (e.cst) begin
        chk({e.name, "_busy_byp1"}, 16'(busy1), 16'(e.bsy));
        chk({e.name, "_done_byp1"}, 16'(done1), 16'(e.dn));
        chk({e.name, "_drop_byp1"}, 16'(drop1), 16'(e.drp));
        chk({e.name, "_busy_byp0"}, 16'(busy0), 16'(e.bsy));
        chk({e.name, "_done_byp0"}, 16'(done0), 16'(e.dn));
        chk({e.name, "_drop_byp0"}, 16'(drop0), 16'(e.drp));
      end
    end
  end

  // Drive one cycle of inputs, queue the outputs expected after the coming edge.
  task automatic cyc(input logic rst, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [2:0] ra, input logic [2:0] rb, input logic clr, input exp_t e);
    reset = rst; we = w; waddr = wa; wdata = wd;
    raddr_a = ra; raddr_b = rb; clear = clr;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 3'(i), 16'(16'hA5A0 + i), 3'd0, 3'd0, 1'b0, xs(xn(), "fill", 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    @(negedge clk);

    // Reset and read back zeros
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd7, 1'b0, xn());
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd7, 1'b0,
        xs(xr(xn(), "reset", 16'h0, 1'b0, 16'h0, 1'b0), "reset", 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd7, 1'b0, xr(xn(), "post_reset", 16'h0, 1'b0, 16'h0, 1'b0));

    // Write latency and unwritten entry
    cyc(1'b0, 1'b1, 3'd5, 16'hBEEF, 3'd4, 3'd4, 1'b0, xr(xn(), "unwritten", 16'h0, 1'b0, 16'h0, 1'b0));
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd4, 1'b0, xr(xn(), "wr_rd", 16'hBEEF, 1'b1, 16'h0, 1'b0));

    // Same-cycle read/write: bypass vs old content
    cyc(1'b0, 1'b1, 3'd2, 16'h1111, 3'd0, 3'd0, 1'b0, xn());
    e = xr(xn(), "bypass", 16'h2222, 1'b1, 16'h2222, 1'b1);
    e.a0 = 16'h1111; e.b0 = 16'h1111;
    cyc(1'b0, 1'b1, 3'd2, 16'h2222, 3'd2, 3'd2, 1'b0, e);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 1'b0, xr(xn(), "after_bypass", 16'h2222, 1'b1, 16'h2222, 1'b1));

    // Full sweep over a filled bank
    fill();
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd7, 1'b1,
        xs(xr(xn(), "sweep_e0", 16'hA5A7, 1'b1, 16'hA5A7, 1'b1), "sweep_e0", 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 8; k++) begin
      e = xr(xn(), $sformatf("sweep_k%0d", k), 16'h0, 1'b0, 16'h0, 1'b0);
      e.a0 = 16'(16'hA5A0 + k - 1); e.va0 = 1'b1;
      if (k == 1) begin
        e.b1 = 16'hA5A7; e.vb1 = 1'b1; e.b0 = 16'hA5A7; e.vb0 = 1'b1;
      end
      e = xs(e, e.name, (k < 8), (k == 8), 1'b0);
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'(k - 1), (k == 1) ? 3'd7 : 3'(k - 2), 1'b0, e);
    end
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0,
          xs(xr(xn(), "post_sweep", 16'h0, 1'b0, 16'h0, 1'b0), "post_sweep", 1'b0, 1'b0, 1'b0));

    // Sweep with write at E0, ignored restart, dropped write, restart on done
    cyc(1'b0, 1'b1, 3'd1, 16'h3333, 3'd0, 3'd0, 1'b1,
        xs(xr(xn(), "s2_e0", 16'h0, 1'b0, 16'h0, 1'b0), "s2_e0", 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd0, 1'b0,
        xs(xr(xn(), "s2_k1", 16'h3333, 1'b1, 16'h0, 1'b0), "s2_k1", 1'b1, 1'b0, 1'b0));
    e = xr(xn(), "s2_k2", 16'h0, 1'b0, 16'h0, 1'b0);
    e.a0 = 16'h3333; e.va0 = 1'b1; e.b0 = 16'h3333; e.vb0 = 1'b1;
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd1, 1'b1, xs(e, "s2_k2", 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 3'd1, 16'h7777, 3'd1, 3'd2, 1'b0,
        xs(xr(xn(), "s2_k3_drop", 16'h0, 1'b0, 16'h0, 1'b0), "s2_k3_drop", 1'b1, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd1, 1'b0,
        xs(xr(xn(), "s2_k4", 16'h0, 1'b0, 16'h0, 1'b0), "s2_k4", 1'b1, 1'b0, 1'b0));
    for (int k = 5; k <= 8; k++)
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd1, 1'b0,
          xs(xr(xn(), $sformatf("s2_k%0d", k), 16'h0, 1'b0, 16'h0, 1'b0), $sformatf("s2_k%0d", k),
             (k < 8), (k == 8), 1'b0));
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, xs(xn(), "restart_on_done", 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 8; k++)
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0,
          xs(xn(), $sformatf("s3_k%0d", k), (k < 8), (k == 8), 1'b0));

    // Reset mid-sweep
    fill();
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, xs(xn(), "s4_e0", 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 3; k++)
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, xs(xn(), "s4_run", 1'b1, 1'b0, 1'b0));
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 3'd5, 3'd6, 1'b0,
        xs(xr(xn(), "mid_reset", 16'h0, 1'b0, 16'h0, 1'b0), "mid_reset", 1'b0, 1'b0, 1'b0));
    for (int j = 0; j < 8; j++)
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'(j), 3'(7 - j), 1'b0,
          xs(xr(xn(), "after_mid_reset", 16'h0, 1'b0, 16'h0, 1'b0), "after_mid_reset", 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 3'd6, 16'h0042, 3'd0, 3'd0, 1'b0, xs(xn(), "wr_after_reset", 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd6, 3'd6, 1'b0, xr(xn(), "rd_after_reset", 16'h0042, 1'b1, 16'h0042, 1'b1));

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
